ws_pixel_decoder: RTL

WS_PIXEL_DECODER -- requirements
Module: ws_pixel_decoder

---
 rtl/ws_pixel_decoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ws_pixel_decoder.sv
// WS281x-style single-wire LED data decoder: measures high/low run lengths on din,
// decodes bits by high time, assembles pixel words and flags treset and timing errors.
module ws_pixel_decoder #(
  parameter int WIDTH          = 12,
  parameter int BITS_PER_PIXEL = 24,
  parameter int TH_MIN         = 10,
  parameter int T1H_MIN        = 30,
  parameter int TH_MAX         = 50,
  parameter int TRESET_CYC     = 2000,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic                      pixel_valid,
  output logic                      frame_start,
  output logic                      bit_error,
  output logic [CNT_W-1:0]          pixel_count
);

  localparam int IDX_W = $clog2(BITS_PER_PIXEL);
  localparam int WP1   = WIDTH + 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BITS_PER_PIXEL - 1);
  localparam logic [WIDTH:0]   H_MIN      = WP1'(TH_MIN);
  localparam logic [WIDTH:0]   H_ONE      = WP1'(T1H_MIN);
  localparam logic [WIDTH:0]   H_MAX      = WP1'(TH_MAX);
  // The run counter lags the synchronised line by one cycle, so the
  // TRESET_CYC-th low sample is seen when the counter holds TRESET_CYC-2.
  localparam logic [WIDTH-1:0] TRESET_RUN = WIDTH'(TRESET_CYC - 2);

  typedef enum logic [0:0] {WAIT_RESET = 1'b0, ACTIVE = 1'b1} state_t;

  logic                      sync1_r, sync2_r, sync3_r;
  logic                      rise_s, fall_s, edge_s, treset_s;
  logic [WIDTH-1:0]          run_cnt_r;
  logic [WIDTH:0]            high_s;
  logic                      s1_valid_r, s1_bit_r, s1_err_r, s1_treset_r;
  state_t                    state_r, state_s;
  logic [BITS_PER_PIXEL-1:0] shift_r, shift_s, word_s, pixel_data_r, data_s;
  logic [IDX_W-1:0]          idx_r, idx_s;
  logic [CNT_W-1:0]          pixel_count_r, count_s;
  logic                      pixel_valid_r, frame_start_r, bit_error_r;
  logic                      pv_s, fs_s, be_s;

  assign rise_s   = sync2_r & ~sync3_r;
  assign fall_s   = sync3_r & ~sync2_r;
  assign edge_s   = rise_s | fall_s;
  assign high_s   = {1'b0, run_cnt_r} + {{WIDTH{1'b0}}, 1'b1};
  assign treset_s = ~sync2_r & ~sync3_r & (run_cnt_r == TRESET_RUN);

  // Two-flop synchroniser followed by the edge-detect register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Saturating run-length counter, restarted on every line edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_r <= {WIDTH{1'b0}};
    end else if (edge_s) begin
      run_cnt_r <= {WIDTH{1'b0}};
    end else if (run_cnt_r != {WIDTH{1'b1}}) begin
      run_cnt_r <= run_cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      run_cnt_r <= run_cnt_r;
    end
  end

  // Stage 1: classify the finished high pulse and register treset detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_bit_r    <= 1'b0;
      s1_err_r    <= 1'b0;
      s1_treset_r <= 1'b0;
    end else begin
      s1_valid_r  <= fall_s;
      s1_bit_r    <= (high_s >= H_ONE);
      s1_err_r    <= (high_s < H_MIN) || (high_s > H_MAX);
      s1_treset_r <= treset_s;
    end
  end

  // Stage 2 next-state: frame tracking, word assembly and strobes.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    data_s  = pixel_data_r;
    count_s = pixel_count_r;
    word_s  = {shift_r[BITS_PER_PIXEL-2:0], s1_bit_r};
    pv_s    = 1'b0;
    fs_s    = s1_treset_r;
    be_s    = s1_valid_r & s1_err_r;
    if (s1_treset_r) begin
      state_s = ACTIVE;
      shift_s = {BITS_PER_PIXEL{1'b0}};
      idx_s   = {IDX_W{1'b0}};
      count_s = {CNT_W{1'b0}};
    end else if (s1_valid_r) begin
      case (state_r)
        ACTIVE: begin
          if (s1_err_r) begin
            state_s = WAIT_RESET;
            shift_s = {BITS_PER_PIXEL{1'b0}};
            idx_s   = {IDX_W{1'b0}};
          end else if (idx_r == IDX_LAST) begin
            data_s  = word_s;
            pv_s    = 1'b1;
            shift_s = {BITS_PER_PIXEL{1'b0}};
            idx_s   = {IDX_W{1'b0}};
            if (pixel_count_r != {CNT_W{1'b1}}) begin
              count_s = pixel_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              count_s = pixel_count_r;
            end
          end else begin
            shift_s = word_s;
            idx_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        WAIT_RESET: begin
          state_s = WAIT_RESET;
        end
        default: begin
          state_s = WAIT_RESET;
          shift_s = {BITS_PER_PIXEL{1'b0}};
          idx_s   = {IDX_W{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Stage 2 registers; all outputs come straight from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= WAIT_RESET;
      shift_r       <= {BITS_PER_PIXEL{1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      pixel_data_r  <= {BITS_PER_PIXEL{1'b0}};
      pixel_count_r <= {CNT_W{1'b0}};
      pixel_valid_r <= 1'b0;
      frame_start_r <= 1'b0;
      bit_error_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      shift_r       <= shift_s;
      idx_r         <= idx_s;
      pixel_data_r  <= data_s;
      pixel_count_r <= count_s;
      pixel_valid_r <= pv_s;
      frame_start_r <= fs_s;
      bit_error_r   <= be_s;
    end
  end

  assign pixel_data  = pixel_data_r;
  assign pixel_valid = pixel_valid_r;
  assign frame_start = frame_start_r;
  assign bit_error   = bit_error_r;
  assign pixel_count = pixel_count_r;

endmodule
